// File: rtl/branch_predict_unit.sv
// D-stage branch resolver with a PC-indexed table of 2-bit saturating counters for F-stage prediction.
// Define BRANCH_STATS_EN to build the resolved-branch / mispredict statistics counters.
module branch_predict_unit #(
    parameter int W        = 32,
    parameter int PHT_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_f,
    output logic             pred_f,
    input  logic [31:0]      instr_d,
    input  logic [31:0]      pc_d,
    input  logic             pred_d,
    input  logic [W-1:0]     D1,
    input  logic [W-1:0]     D2,
    input  logic             en_d,
    output logic             is_branch,
    output logic             branch,
    output logic             link,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int PHT_N = 1 << PHT_BITS;

    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return nxt;
    endfunction

    logic [1:0]          pht_r [PHT_N];
    logic [5:0]          op_s;
    logic [4:0]          rt_s;
    logic                d1_neg_s;
    logic                d1_zero_s;
    logic                upd_s;
    logic [PHT_BITS-1:0] idx_f_s;
    logic [PHT_BITS-1:0] idx_d_s;
    logic                unused_s;

    assign op_s      = instr_d[31:26];
    assign rt_s      = instr_d[20:16];
    assign d1_neg_s  = D1[W-1];
    assign d1_zero_s = (D1 == {W{1'b0}});
    assign idx_f_s   = pc_f[PHT_BITS+1:2];
    assign idx_d_s   = pc_d[PHT_BITS+1:2];
    assign unused_s  = ^{pc_f[31:PHT_BITS+2], pc_f[1:0], pc_d[31:PHT_BITS+2], pc_d[1:0],
                         instr_d[25:21], instr_d[15:0]};

    // Branch decode and direction resolution from the forwarded operands
    always_comb begin
        is_branch = 1'b0;
        branch    = 1'b0;
        link      = 1'b0;
        case (op_s)
            6'b000100: begin is_branch = 1'b1; branch = (D1 == D2); end
            6'b000101: begin is_branch = 1'b1; branch = (D1 != D2); end
            6'b000110: begin is_branch = 1'b1; branch = d1_neg_s | d1_zero_s; end
            6'b000111: begin is_branch = 1'b1; branch = ~d1_neg_s & ~d1_zero_s; end
            6'b000001: begin
                case (rt_s)
                    5'b00000, 5'b10000: begin
                        is_branch = 1'b1;
                        branch    = d1_neg_s;
                        link      = rt_s[4];
                    end
                    5'b00001, 5'b10001: begin
                        is_branch = 1'b1;
                        branch    = ~d1_neg_s;
                        link      = rt_s[4];
                    end
                    default: begin
                        is_branch = 1'b0;
                        branch    = 1'b0;
                        link      = 1'b0;
                    end
                endcase
            end
            default: begin
                is_branch = 1'b0;
                branch    = 1'b0;
                link      = 1'b0;
            end
        endcase
    end

    assign upd_s      = en_d & is_branch;
    assign mispredict = upd_s & (branch ^ pred_d);
    // Read-before-write: a same-cycle update to this entry is not visible until after the edge
    assign pred_f     = pht_r[idx_f_s][1];

    // Pattern history table training; reset wins over a same-cycle update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_N; i++) begin
                pht_r[i] <= 2'b01;
            end
        end else if (upd_s) begin
            pht_r[idx_d_s] <= sat_step(pht_r[idx_d_s], branch);
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_r;
    logic [CNT_W-1:0] miss_cnt_r;

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_r   <= {CNT_W{1'b0}};
            miss_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (upd_s && (br_cnt_r != {CNT_W{1'b1}})) begin
                br_cnt_r <= br_cnt_r + CNT_W'(1);
            end
            if (mispredict && (miss_cnt_r != {CNT_W{1'b1}})) begin
                miss_cnt_r <= miss_cnt_r + CNT_W'(1);
            end
        end
    end

    assign br_cnt   = br_cnt_r;
    assign miss_cnt = miss_cnt_r;
`else
    assign br_cnt   = {CNT_W{1'b0}};
    assign miss_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus a randomized run
// checked against an array-of-integers predictor model.
module tb_branch_predict_unit;
    localparam int W  = 32;
    localparam int PB = 6;
    localparam int CW = 32;
`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc_f, instr_d, pc_d;
    logic          pred_d, en_d;
    logic [W-1:0]  d1, d2;
    logic          pred_f, is_branch, branch, link, mispredict;
    logic [CW-1:0] br_cnt, miss_cnt;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     m_pht [64];
    longint m_br, m_miss;

    branch_predict_unit #(.W(W), .PHT_BITS(PB), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .pc_f(pc_f), .pred_f(pred_f), .instr_d(instr_d),
        .pc_d(pc_d), .pred_d(pred_d), .D1(d1), .D2(d2), .en_d(en_d),
        .is_branch(is_branch), .branch(branch), .link(link), .mispredict(mispredict),
        .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int op, input int rt);
        logic [31:0] v;
        v = 32'd0;
        v[31:26] = op[5:0];
        v[20:16] = rt[4:0];
        v[15:0]  = 16'h1234;
        return v;
    endfunction

    // Reference decode straight from the branch rules
    task automatic ref_decode(input logic [31:0] ins, input logic [W-1:0] a, input logic [W-1:0] b,
                              output bit isb, output bit tk, output bit lk);
        int op, rt;
        longint sa;
        op = int'(ins[31:26]);
        rt = int'(ins[20:16]);
        sa = longint'($signed(a));
        isb = 1'b0; tk = 1'b0; lk = 1'b0;
        if (op == 4)      begin isb = 1; tk = (a == b); end
        else if (op == 5) begin isb = 1; tk = (a != b); end
        else if (op == 6) begin isb = 1; tk = (sa <= 0); end
        else if (op == 7) begin isb = 1; tk = (sa > 0); end
        else if (op == 1 && (rt == 0 || rt == 16)) begin isb = 1; tk = (sa < 0);  lk = (rt == 16); end
        else if (op == 1 && (rt == 1 || rt == 17)) begin isb = 1; tk = (sa >= 0); lk = (rt == 17); end
    endtask

    function automatic int pidx(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_pht[pidx(pc)] >= 2;
    endfunction

    function automatic longint exp_br();
        return STATS ? m_br : 64'd0;
    endfunction

    function automatic longint exp_miss();
        return STATS ? m_miss : 64'd0;
    endfunction

    // Advance one clock edge and apply the same edge to the model
    task automatic tick();
        bit isb, tk, lk;
        ref_decode(instr_d, d1, d2, isb, tk, lk);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 64; i++) m_pht[i] = 1;
            m_br = 0;
            m_miss = 0;
        end else if (en_d && isb) begin
            if (tk) m_pht[pidx(pc_d)] = (m_pht[pidx(pc_d)] == 3) ? 3 : m_pht[pidx(pc_d)] + 1;
            else    m_pht[pidx(pc_d)] = (m_pht[pidx(pc_d)] == 0) ? 0 : m_pht[pidx(pc_d)] - 1;
            m_br++;
            if (tk != pred_d) m_miss++;
        end
        #1;
    endtask

    task automatic set_d(input logic [31:0] ins, input logic [31:0] pcd, input logic pd,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic en);
        instr_d = ins; pc_d = pcd; pred_d = pd; d1 = a; d2 = b; en_d = en;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pc_f = 32'h3000;
        set_d(32'd0, 32'h3000, 1'b0, '0, '0, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (pred_f !== 1'b0) $display("FAIL reset_pred_3000: got %0b expected 0", pred_f); else n_pass++;
        pc_f = 32'h30FC; #1;
        n_checks++; if (pred_f !== 1'b0) $display("FAIL reset_pred_30fc: got %0b expected 0", pred_f); else n_pass++;
        n_checks++; if (br_cnt !== '0) $display("FAIL reset_br_cnt: got %0d expected 0", br_cnt); else n_pass++;
        n_checks++; if (miss_cnt !== '0) $display("FAIL reset_miss_cnt: got %0d expected 0", miss_cnt); else n_pass++;
    endtask

    task automatic test_signed_compare();
        logic [31:0] ins [6];
        logic [W-1:0] a [6];
        logic [W-1:0] b [6];
        bit exp [6];
        ins[0] = mk(7, 0); a[0] = 32'h0;        b[0] = 32'h0; exp[0] = 1'b0;
        ins[1] = mk(6, 0); a[1] = 32'h0;        b[1] = 32'h0; exp[1] = 1'b1;
        ins[2] = mk(1, 0); a[2] = 32'h80000000; b[2] = 32'h0; exp[2] = 1'b1;
        ins[3] = mk(1, 1); a[3] = 32'h7FFFFFFF; b[3] = 32'h0; exp[3] = 1'b1;
        ins[4] = mk(4, 0); a[4] = 32'd5;        b[4] = 32'd5; exp[4] = 1'b1;
        ins[5] = mk(5, 0); a[5] = 32'd5;        b[5] = 32'd5; exp[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_d(ins[i], 32'h3000, 1'b0, a[i], b[i], 1'b0);
            #1;
            n_checks++;
            if (branch !== exp[i] || is_branch !== 1'b1)
                $display("FAIL signed_cmp_%0d: got branch=%0b is_branch=%0b expected branch=%0b is_branch=1",
                         i, branch, is_branch, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_training();
        bit exp_p [5];
        exp_p[0] = 1; exp_p[1] = 1; exp_p[2] = 1; exp_p[3] = 1; exp_p[4] = 0;
        pc_f = 32'h3010;
        for (int i = 0; i < 5; i++) begin
            set_d(mk(4, 0), 32'h3010, 1'b0, 32'd7, (i < 3) ? 32'd7 : 32'd8, 1'b1);
            #1;
            n_checks++;
            if (mispredict !== (i < 3)) $display("FAIL train_mispredict_%0d: got %0b expected %0b", i, mispredict, (i < 3));
            else n_pass++;
            tick();
            n_checks++;
            if (pred_f !== exp_p[i] || pred_f !== m_pred(pc_f))
                $display("FAIL train_pred_%0d: got %0b expected %0b", i, pred_f, exp_p[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        longint base;
        base = exp_br();
        pc_f = 32'h3020;
        for (int i = 0; i < 5; i++) begin
            set_d(mk(4, 0), 32'h3020, 1'b0, 32'd3, 32'd3, 1'b0);
            #1;
            n_checks++; if (mispredict !== 1'b0) $display("FAIL stall_mispredict_%0d: got %0b expected 0", i, mispredict); else n_pass++;
            tick();
        end
        n_checks++; if (pred_f !== 1'b0) $display("FAIL stall_pred: got %0b expected 0", pred_f); else n_pass++;
        n_checks++; if (longint'(br_cnt) !== base) $display("FAIL stall_br_cnt: got %0d expected %0d", br_cnt, base); else n_pass++;
        // One enabled taken update from 01 must reach weak-taken
        en_d = 1'b1;
        tick();
        n_checks++; if (pred_f !== 1'b1) $display("FAIL stall_entry_01: got %0b expected 1", pred_f); else n_pass++;
    endtask

    task automatic test_link_decode();
        set_d(mk(1, 17), 32'h3040, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0); #1;
        n_checks++;
        if ({is_branch, branch, link} !== 3'b101)
            $display("FAIL bgezal_decode: got %3b expected 101", {is_branch, branch, link});
        else n_pass++;
        set_d(mk(1, 16), 32'h3040, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b0); #1;
        n_checks++;
        if ({is_branch, branch, link} !== 3'b111)
            $display("FAIL bltzal_decode: got %3b expected 111", {is_branch, branch, link});
        else n_pass++;
        set_d(mk(1, 2), 32'h3040, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1); #1;
        n_checks++;
        if ({is_branch, branch, link, mispredict} !== 4'b0000)
            $display("FAIL rt2_decode: got %4b expected 0000", {is_branch, branch, link, mispredict});
        else n_pass++;
    endtask

    task automatic test_stats();
        longint b0, m0;
        b0 = m_br; m0 = m_miss;
        // taken/pred0, taken/pred1, not-taken/pred0, not-taken/pred1 -> 2 mispredicts
        set_d(mk(4, 0), 32'h3080, 1'b0, 32'd1, 32'd1, 1'b1); tick();
        set_d(mk(4, 0), 32'h3084, 1'b1, 32'd1, 32'd1, 1'b1); tick();
        set_d(mk(5, 0), 32'h3088, 1'b0, 32'd1, 32'd1, 1'b1); tick();
        set_d(mk(5, 0), 32'h308C, 1'b1, 32'd1, 32'd1, 1'b1); tick();
        n_checks++;
        if (longint'(br_cnt) !== (STATS ? b0 + 4 : 64'd0)) $display("FAIL stats_br_cnt: got %0d expected %0d", br_cnt, STATS ? b0 + 4 : 64'd0);
        else n_pass++;
        n_checks++;
        if (longint'(miss_cnt) !== (STATS ? m0 + 2 : 64'd0)) $display("FAIL stats_miss_cnt: got %0d expected %0d", miss_cnt, STATS ? m0 + 2 : 64'd0);
        else n_pass++;
        // Train 0x3010 up, then reset on a cycle that would also train it
        pc_f = 32'h3010;
        set_d(mk(4, 0), 32'h3010, 1'b0, 32'd2, 32'd2, 1'b1); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_checks++; if (pred_f !== 1'b0) $display("FAIL rst_mid_pred: got %0b expected 0", pred_f); else n_pass++;
        n_checks++; if (br_cnt !== '0 || miss_cnt !== '0) $display("FAIL rst_mid_cnts: got %0d/%0d expected 0/0", br_cnt, miss_cnt); else n_pass++;
        tick();
        n_checks++; if (pred_f !== 1'b1) $display("FAIL rst_mid_entry_01: got %0b expected 1", pred_f); else n_pass++;
    endtask

    task automatic test_random();
        int ops [11];
        int rts [7];
        bit isb, tk, lk;
        ops = '{4, 5, 6, 7, 1, 1, 1, 0, 2, 8, 35};
        rts = '{0, 1, 16, 17, 2, 3, 31};
        for (int c = 0; c < 400; c++) begin
            int op, rt;
            logic [W-1:0] a, b;
            op = ops[$urandom_range(10, 0)];
            rt = (op == 1) ? rts[$urandom_range(6, 0)] : int'($urandom_range(31, 0));
            a = $urandom;
            case ($urandom_range(3, 0))
                0: a = '0;
                1: a = {1'b1, {(W-1){1'b0}}};
                default: a = $urandom;
            endcase
            b = ($urandom_range(1, 0) == 0) ? a : W'($urandom);
            reset = ($urandom_range(59, 0) == 0);
            // Narrow PC range so entries get trained repeatedly; upper bits exercise aliasing
            set_d(mk(op, rt), {20'h3, 4'($urandom), 6'($urandom_range(15, 0)), 2'b00},
                  1'($urandom), a, b, ($urandom_range(3, 0) != 0));
            pc_f = {20'h3, 4'($urandom), 6'($urandom_range(15, 0)), 2'b00};
            #1;
            ref_decode(instr_d, d1, d2, isb, tk, lk);
            n_checks++; if (is_branch !== isb) $display("FAIL rnd_is_branch c%0d: got %0b expected %0b", c, is_branch, isb); else n_pass++;
            n_checks++; if (branch !== (isb & tk)) $display("FAIL rnd_branch c%0d: got %0b expected %0b", c, branch, isb & tk); else n_pass++;
            n_checks++; if (link !== lk) $display("FAIL rnd_link c%0d: got %0b expected %0b", c, link, lk); else n_pass++;
            n_checks++;
            if (mispredict !== (en_d & isb & (tk != pred_d)))
                $display("FAIL rnd_mispredict c%0d: got %0b expected %0b", c, mispredict, en_d & isb & (tk != pred_d));
            else n_pass++;
            n_checks++; if (pred_f !== m_pred(pc_f)) $display("FAIL rnd_pred_f c%0d: got %0b expected %0b", c, pred_f, m_pred(pc_f)); else n_pass++;
            tick();
            n_checks++; if (longint'(br_cnt) !== exp_br()) $display("FAIL rnd_br_cnt c%0d: got %0d expected %0d", c, br_cnt, exp_br()); else n_pass++;
            n_checks++; if (longint'(miss_cnt) !== exp_miss()) $display("FAIL rnd_miss_cnt c%0d: got %0d expected %0d", c, miss_cnt, exp_miss()); else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        m_br = 0;
        m_miss = 0;
        for (int i = 0; i < 64; i++) m_pht[i] = 1;
        test_reset();
        test_signed_compare();
        test_training();
        test_stall();
        test_link_decode();
        test_stats();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- D-stage branch resolver for the 5-stage MIPS pipeline, generalised over datapath width.
- Adds a PC-indexed pattern history table (PHT) of 2-bit saturating counters. F stage reads it for a taken/not-taken prediction; D stage resolves the branch, flags mispredicts and trains the table.
- Sits beside the D-stage register-file read ports, with a lookup port into F.

Parameters:
- W, 32, compare operand width in bits (signed two's complement).
- PHT_BITS, 6, log2 of PHT entry count (64 entries).
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_f  in  32  F-stage PC, used for lookup.
- pred_f  out  1  F-stage prediction (1 = taken).
- instr_d  in  32  D-stage instruction.
- pc_d  in  32  D-stage PC, used for training.
- pred_d  in  1  prediction carried with instr_d from F.
- D1  in  W  forwarded rs value.
- D2  in  W  forwarded rt value.
- en_d  in  1  D stage advances this cycle (not stalled, not flushed).
- is_branch  out  1  instr_d is a supported branch.
- branch  out  1  resolved taken.
- link  out  1  instr_d is bltzal/bgezal (GPR31 write required).
- mispredict  out  1  en_d & is_branch & (branch != pred_d).
- br_cnt  out  CNT_W  resolved branches (stats).
- miss_cnt  out  CNT_W  mispredicts (stats).

Behaviour:
- Decode is on op = instr_d[31:26] and rt = instr_d[20:16]:
  - beq 000100: taken when D1==D2.
  - bne 000101: taken when D1!=D2.
  - blez 000110: taken when signed D1<=0.
  - bgtz 000111: taken when signed D1>0.
  - op 000001 with rt 00000 (bltz) or 10000 (bltzal): taken when D1[W-1]==1.
  - op 000001 with rt 00001 (bgez) or 10001 (bgezal): taken when D1[W-1]==0.
  - Any other op/rt gives is_branch=0, branch=0, link=0.
- link=1 for bltzal/bgezal regardless of direction.
- is_branch, branch, link and mispredict are combinational from the D inputs, with zero latency.
- PHT index is pc[PHT_BITS+1:2]. Entry encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- pred_f = PHT[idx(pc_f)][1], combinational read.
- Update happens at the rising edge when en_d & is_branch:
  - Taken: counter increments, saturating at 11.
  - Not taken: counter decrements, saturating at 00.
  - No update when en_d=0 or is_branch=0.
- Same-cycle read and write to the same index: pred_f returns the pre-update value, with no bypass.
- Reset values: every PHT entry 01, br_cnt=0, miss_cnt=0. Combinational outputs follow their inputs during reset.
- Reset has priority over update. Reset mid-stream discards that cycle's training and restores all entries to 01 at the edge.
- Outside reset, D1/D2 are don't-care for non-branches.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - br_cnt increments on each edge with en_d & is_branch.
  - miss_cnt increments on each edge with mispredict.
  - Both saturate at all-ones with no wrap, and both clear on reset.
- Undefined: br_cnt and miss_cnt are constant 0 and no counter flops are built. PHT behaviour is unchanged.

Test Plan:
- Post-reset lookup: reset 1 cycle, then pc_f=0x3000 -> pred_f=0. Repeat for pc_f=0x30FC -> pred_f=0 (all entries 01).
- Signed compares, W=32:
  - bgtz with D1=0 -> branch=0.
  - blez with D1=0 -> branch=1.
  - bltz with D1=0x80000000 -> branch=1.
  - bgez with D1=0x7FFFFFFF -> branch=1.
  - beq with D1=D2=5 -> branch=1.
  - bne with D1=D2=5 -> branch=0.
- Training with saturation: pc_d=0x3010, beq taken, en_d=1, pred_d=0 for 3 cycles:
  - Cycle 1 mispredict=1; pred_f at pc_f=0x3010 goes 1 after the first edge.
  - Counter reaches 11 after the second edge and holds at 11.
  - Then 1 not-taken -> 10, pred_f still 1.
- Stall gating: en_d=0 with taken beq at 0x3020 for 5 cycles -> entry stays 01, br_cnt unchanged, mispredict=0.
- Link and decode: bgezal (op 000001, rt 10001) with D1=0xFFFFFFFF -> is_branch=1, branch=0, link=1. op 000001 with rt 00010 -> is_branch=0.
- Stats and reset (BRANCH_STATS_EN defined): 4 branches with 2 mispredicts -> br_cnt=4, miss_cnt=2. Reset asserted on a cycle with en_d & is_branch -> both 0 and PHT entry 01 after the edge.
